// File: rtl/thread_scheduler.sv
// Fine-grained thread selector for the multithreaded in-order pipeline.
// Each cycle it picks the next thread to fetch (round-robin over runnable
// threads). Threads are parked after an i-cache miss. Exception entry is
// serialised toward IF, one thread per cycle, lowest id first.
module thread_scheduler #(
   parameter int N_THREADS  = 8,
   parameter int TID_W      = $clog2(N_THREADS),
   parameter int IMISS_WAIT = 6
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [N_THREADS-1:0] stalled,
   input  logic                 if_miss_en,
   input  logic [TID_W-1:0]     if_miss_thread,
   input  logic                 if_miss_itlb,
   input  logic                 exc_req_en,
   input  logic [TID_W-1:0]     exc_req_thread,
   output logic [TID_W-1:0]     scheduler_thread,
   output logic                 issue_valid,
   output logic                 exc_en,
   output logic [TID_W-1:0]     exc_thread,
   output logic [N_THREADS-1:0] thread_run
);

   localparam int              CNT_W     = $clog2(IMISS_WAIT + 1);
   localparam logic [CNT_W-1:0] WAIT_LOAD = CNT_W'(IMISS_WAIT);

   typedef enum logic [1:0] {
      RUN      = 2'd0,
      IWAIT    = 2'd1,
      EXC_PEND = 2'd2
   } thr_state_e;

   thr_state_e       state_q [N_THREADS];
   thr_state_e       state_d [N_THREADS];
   logic [CNT_W-1:0] cnt_q   [N_THREADS];
   logic [CNT_W-1:0] cnt_d   [N_THREADS];
   logic [TID_W-1:0] last_grant_q;

   logic [N_THREADS-1:0] eligible;
   logic [N_THREADS-1:0] exc_set;
   logic [N_THREADS-1:0] imiss;
   logic [N_THREADS-1:0] req_hit;
   logic                 fetch_found;
   logic [TID_W-1:0]     fetch_pick;
   logic                 exc_found;
   logic [TID_W-1:0]     exc_pick;

   // Decode the miss/exception event buses into per-thread request vectors.
   always_comb begin
      // NOTE: every variable gets a default before any branch, so no latch is inferred.
      exc_set = '0;
      imiss   = '0;
      req_hit = '0;
      for (int t = 0; t < N_THREADS; t++) begin
         req_hit[t] = exc_req_en && (exc_req_thread == TID_W'(t));
         exc_set[t] = req_hit[t] ||
                      (if_miss_en && if_miss_itlb && (if_miss_thread == TID_W'(t)));
         imiss[t]   = if_miss_en && !if_miss_itlb && (if_miss_thread == TID_W'(t));
      end
   end

   // Round-robin fetch search starting just after the last granted thread.
   always_comb begin
      logic [TID_W-1:0] idx;
      idx         = '0;
      eligible    = '0;
      fetch_found = 1'b0;
      fetch_pick  = '0;
      for (int t = 0; t < N_THREADS; t++)
         eligible[t] = (state_q[t] == RUN) && !stalled[t];
      for (int i = 1; i <= N_THREADS; i++) begin
         idx = TID_W'((int'(last_grant_q) + i) % N_THREADS);
         if (!fetch_found && eligible[idx]) begin
            fetch_found = 1'b1;
            fetch_pick  = idx;
         end
      end
   end

   // Lowest-id pending exception wins the single exception slot.
   always_comb begin
      exc_found = 1'b0;
      exc_pick  = '0;
      for (int t = N_THREADS - 1; t >= 0; t--) begin
         if (state_q[t] == EXC_PEND) begin
            exc_found = 1'b1;
            exc_pick  = TID_W'(t);
         end
      end
   end

   // Per-thread next state; a fresh exception request always beats a park.
   always_comb begin
      for (int t = 0; t < N_THREADS; t++) begin
         state_d[t] = state_q[t];
         cnt_d[t]   = cnt_q[t];
         case (state_q[t])
            RUN: begin
               if (exc_set[t]) begin
                  state_d[t] = EXC_PEND;
               end else if (imiss[t]) begin
                  state_d[t] = IWAIT;
                  cnt_d[t]   = WAIT_LOAD;
               end
            end
            IWAIT: begin
               if (exc_set[t]) begin
                  state_d[t] = EXC_PEND;
                  cnt_d[t]   = '0;
               end else if (imiss[t]) begin
                  cnt_d[t] = WAIT_LOAD;
               end else if (cnt_q[t] == CNT_W'(1)) begin
                  state_d[t] = RUN;
                  cnt_d[t]   = '0;
               end else begin
                  cnt_d[t] = cnt_q[t] - CNT_W'(1);
               end
            end
            EXC_PEND: begin
               // Misses are ignored here; a new request in the grant cycle re-arms it.
               if (!req_hit[t] && exc_found && (exc_pick == TID_W'(t)))
                  state_d[t] = RUN;
            end
            default: begin
               state_d[t] = RUN;
               cnt_d[t]   = '0;
            end
         endcase
      end
   end

   // Per-thread state and park counters.
   always_ff @(posedge clk) begin
      // NOTE: the per-thread arrays are few flops, not a RAM, so they are all reset.
      if (rst) begin
         for (int t = 0; t < N_THREADS; t++) begin
            state_q[t] <= RUN;
            cnt_q[t]   <= '0;
         end
      end else begin
         // NOTE: non-blocking assignments so every flop samples pre-edge values.
         for (int t = 0; t < N_THREADS; t++) begin
            state_q[t] <= state_d[t];
            cnt_q[t]   <= cnt_d[t];
         end
      end
   end

   // Registered fetch grant and exception redirect.
   always_ff @(posedge clk) begin
      if (rst) begin
         last_grant_q     <= TID_W'(N_THREADS - 1);
         scheduler_thread <= '0;
         issue_valid      <= 1'b0;
         exc_en           <= 1'b0;
         exc_thread       <= '0;
      end else begin
         issue_valid <= fetch_found;
         if (fetch_found) begin
            scheduler_thread <= fetch_pick;
            last_grant_q     <= fetch_pick;
         end
         exc_en <= exc_found;
         if (exc_found)
            exc_thread <= exc_pick;
      end
   end

   // Visibility of which threads are currently runnable.
   always_comb begin
      thread_run = '0;
      for (int t = 0; t < N_THREADS; t++)
         thread_run[t] = (state_q[t] == RUN);
   end

endmodule

// File: tb/tb_thread_scheduler.sv
// Self-checking bench for thread_scheduler: directed scenarios followed by
// random traffic, all compared against a wake-time based reference model.
module tb_thread_scheduler;

   localparam int N  = 8;
   localparam int TW = 3;
   localparam int IW = 6;

   logic          clk;
   logic          rst;
   logic [N-1:0]  stalled;
   logic          if_miss_en;
   logic [TW-1:0] if_miss_thread;
   logic          if_miss_itlb;
   logic          exc_req_en;
   logic [TW-1:0] exc_req_thread;
   logic [TW-1:0] scheduler_thread;
   logic          issue_valid;
   logic          exc_en;
   logic [TW-1:0] exc_thread;
   logic [N-1:0]  thread_run;

   thread_scheduler #(.N_THREADS(N), .TID_W(TW), .IMISS_WAIT(IW)) dut (
      .clk              (clk),
      .rst              (rst),
      .stalled          (stalled),
      .if_miss_en       (if_miss_en),
      .if_miss_thread   (if_miss_thread),
      .if_miss_itlb     (if_miss_itlb),
      .exc_req_en       (exc_req_en),
      .exc_req_thread   (exc_req_thread),
      .scheduler_thread (scheduler_thread),
      .issue_valid      (issue_valid),
      .exc_en           (exc_en),
      .exc_thread       (exc_thread),
      .thread_run       (thread_run)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int n_checks = 0;
   int n_pass   = 0;

   // Reference model: a thread is pending an exception, or runnable once the
   // edge count reaches its wake time.
   bit            m_pend [N];
   int            m_wake [N];
   int            m_now;
   int            m_last;
   logic [TW-1:0] m_sched;
   logic          m_valid;
   logic          m_exc_en;
   logic [TW-1:0] m_exc_thread;

   function automatic logic [N-1:0] model_run();
      logic [N-1:0] r;
      r = '0;
      for (int t = 0; t < N; t++) r[t] = !m_pend[t] && (m_now >= m_wake[t]);
      return r;
   endfunction

   task automatic model_reset();
      for (int t = 0; t < N; t++) begin
         m_pend[t] = 1'b0;
         m_wake[t] = 0;
      end
      m_now        = 0;
      m_last       = N - 1;
      m_sched      = '0;
      m_valid      = 1'b0;
      m_exc_en     = 1'b0;
      m_exc_thread = '0;
   endtask

   task automatic model_step();
      logic [N-1:0] elig;
      int g_exc, pick, idx, n;
      bit miss_hit, req_hit;
      elig  = model_run() & ~stalled;
      g_exc = -1;
      for (int t = 0; t < N; t++) if (m_pend[t] && g_exc < 0) g_exc = t;
      pick = -1;
      for (int i = 1; i <= N; i++) begin
         idx = (m_last + i) % N;
         if (pick < 0 && elig[idx]) pick = idx;
      end
      n = m_now + 1;
      for (int t = 0; t < N; t++) begin
         miss_hit = if_miss_en && (int'(if_miss_thread) == t);
         req_hit  = exc_req_en && (int'(exc_req_thread) == t);
         if (m_pend[t]) begin
            if (!req_hit && t == g_exc) begin
               m_pend[t] = 1'b0;
               m_wake[t] = 0;
            end
         end else if (req_hit || (miss_hit && if_miss_itlb)) begin
            m_pend[t] = 1'b1;
         end else if (miss_hit) begin
            m_wake[t] = n + IW;
         end
      end
      m_now    = n;
      m_exc_en = (g_exc >= 0);
      if (g_exc >= 0) m_exc_thread = TW'(g_exc);
      m_valid = (pick >= 0);
      if (pick >= 0) begin
         m_sched = TW'(pick);
         m_last  = pick;
      end
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed=%0h expected=%0h at edge %0d", tag, obs, exp, m_now);
   endtask

   // Advance one clock: model sees the same inputs as the DUT, sample #1 after the edge.
   task automatic tick();
      if (rst) model_reset();
      else     model_step();
      @(posedge clk);
      #1;
      check("sched",      32'(scheduler_thread), 32'(m_sched));
      check("valid",      32'(issue_valid),      32'(m_valid));
      check("exc_en",     32'(exc_en),           32'(m_exc_en));
      check("exc_thread", 32'(exc_thread),       32'(m_exc_thread));
      check("thread_run", 32'(thread_run),       32'(model_run()));
   endtask

   task automatic idle_inputs();
      if_miss_en     = 1'b0;
      if_miss_thread = '0;
      if_miss_itlb   = 1'b0;
      exc_req_en     = 1'b0;
      exc_req_thread = '0;
   endtask

   initial begin
      rst     = 1'b1;
      stalled = '0;
      idle_inputs();
      model_reset();

      // 1: reset, then plain round robin 0..7,0,1
      tick();
      tick();
      check("rst_run", 32'(thread_run), 32'hFF);
      check("rst_valid", 32'(issue_valid), 32'h0);
      rst = 1'b0;
      for (int i = 0; i < 10; i++) begin
         tick();
         check("t1_order", 32'(scheduler_thread), 32'(i % N));
         check("t1_valid", 32'(issue_valid), 32'h1);
      end

      // 2: thread 2 stalled, then released
      stalled = 8'b0000_0100;
      for (int i = 0; i < 8; i++) begin
         tick();
         check("t2_skip2", 32'(scheduler_thread == 3'd2), 32'h0);
      end
      stalled = '0;
      for (int i = 0; i < 8; i++) tick();

      // 3: i-cache miss on thread 3 parks it for IMISS_WAIT cycles
      if_miss_en = 1'b1; if_miss_thread = 3'd3; if_miss_itlb = 1'b0;
      tick();
      idle_inputs();
      check("t3_park", 32'(thread_run[3]), 32'h0);
      for (int i = 0; i < IW - 1; i++) begin
         tick();
         check("t3_park", 32'(thread_run[3]), 32'h0);
      end
      tick();
      check("t3_wake", 32'(thread_run[3]), 32'h1);
      for (int i = 0; i < 8; i++) tick();

      // 4: exception request 5 and iTLB miss 2 in the same cycle
      exc_req_en = 1'b1; exc_req_thread = 3'd5;
      if_miss_en = 1'b1; if_miss_thread = 3'd2; if_miss_itlb = 1'b1;
      tick();
      idle_inputs();
      check("t4_none", 32'(exc_en), 32'h0);
      tick();
      check("t4_first_en", 32'(exc_en), 32'h1);
      check("t4_first_id", 32'(exc_thread), 32'h2);
      tick();
      check("t4_second_en", 32'(exc_en), 32'h1);
      check("t4_second_id", 32'(exc_thread), 32'h5);
      tick();
      check("t4_done", 32'(exc_en), 32'h0);

      // 5: everything stalled, then only thread 0 free
      stalled = 8'hFF;
      for (int i = 0; i < 4; i++) begin
         tick();
         check("t5_nogrant", 32'(issue_valid), 32'h0);
      end
      stalled = 8'hFE;
      for (int i = 0; i < 4; i++) begin
         tick();
         check("t5_only0", 32'(scheduler_thread), 32'h0);
         check("t5_valid", 32'(issue_valid), 32'h1);
      end
      stalled = '0;

      // 6: reset in the middle of a park
      if_miss_en = 1'b1; if_miss_thread = 3'd4; if_miss_itlb = 1'b0;
      tick();
      idle_inputs();
      tick();
      rst = 1'b1;
      tick();
      tick();
      check("t6_run", 32'(thread_run), 32'hFF);
      check("t6_exc", 32'(exc_en), 32'h0);
      rst = 1'b0;
      tick();
      check("t6_first", 32'(scheduler_thread), 32'h0);
      check("t6_valid", 32'(issue_valid), 32'h1);
      check("t6_noexc", 32'(exc_en), 32'h0);

      // Random traffic against the model
      for (int i = 0; i < 600; i++) begin
         rst            = ($urandom_range(0, 99) == 0);
         stalled        = N'($urandom & $urandom & $urandom);
         if_miss_en     = ($urandom_range(0, 3) == 0);
         if_miss_thread = TW'($urandom);
         if_miss_itlb   = ($urandom_range(0, 3) == 0);
         exc_req_en     = ($urandom_range(0, 7) == 0);
         exc_req_thread = TW'($urandom);
         tick();
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
